// File: rtl/qa_drv_prim_fifo_pkg.sv
// Shared helpers for the QA driver FIFO primitives: index and occupancy-counter widths.
package qa_drv_prim_fifo_pkg;

    // LUTRAM index width for a FIFO whose head lives in a flop (N_ENTRIES-1 RAM slots).
    function automatic int unsigned fifo_idx_width(input int unsigned n_entries);
        if (n_entries <= 32'd2) begin
            return 32'd1;
        end else begin
            return int'($clog2(n_entries - 32'd1));
        end
    endfunction

    // Counter width able to hold every occupancy from 0 to n_entries inclusive.
    function automatic int unsigned fifo_cnt_width(input int unsigned n_entries);
        return int'($clog2(n_entries + 32'd1));
    endfunction

endpackage

// File: rtl/qa_drv_prim_lutram_sdp.sv
// Simple dual-port distributed RAM: synchronous write, asynchronous read, contents never reset.
module qa_drv_prim_lutram_sdp #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    (* ram_style = "distributed", ramstyle = "MLAB" *)
    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port; no reset so the array maps onto LUT/MLAB storage.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/qa_drv_prim_fifo_lutram_reg.sv
// LUTRAM FIFO whose head entry is held in a flop, so `first` never sees the RAM read path.
module qa_drv_prim_fifo_lutram_reg
    import qa_drv_prim_fifo_pkg::*;
#(
    parameter int unsigned N_DATA_BITS  = 32,
    parameter int unsigned N_ENTRIES    = 4,
    parameter int unsigned AF_THRESHOLD = 1,
    parameter int unsigned AE_THRESHOLD = 1
) (
    input  logic                             clk,
    input  logic                             resetb,
    input  logic [N_DATA_BITS-1:0]           enq_data,
    input  logic                             enq_en,
    output logic                             notFull,
    output logic                             almostFull,
    output logic [N_DATA_BITS-1:0]           first,
    input  logic                             deq_en,
    output logic                             notEmpty,
    output logic                             almostEmpty,
    output logic [$clog2(N_ENTRIES+1)-1:0]   count,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int unsigned AW        = fifo_idx_width(N_ENTRIES);
    localparam int unsigned CW        = fifo_cnt_width(N_ENTRIES);
    localparam int unsigned RAM_DEPTH = N_ENTRIES - 1;

    localparam logic [AW-1:0] IDX_LAST   = AW'(N_ENTRIES - 2);
    localparam logic [CW-1:0] FULL_COUNT = CW'(N_ENTRIES);
    localparam logic [CW-1:0] AF_LEVEL   = CW'(N_ENTRIES - AF_THRESHOLD);
    localparam logic [CW-1:0] AE_LEVEL   = CW'(AE_THRESHOLD);
    localparam logic          AF_RESET   = (AF_THRESHOLD >= N_ENTRIES) ? 1'b1 : 1'b0;

    if (N_ENTRIES < 2) begin : g_chk_entries
        $error("qa_drv_prim_fifo_lutram_reg: N_ENTRIES must be at least 2");
    end
    if (AF_THRESHOLD >= N_ENTRIES) begin : g_chk_af
        $error("qa_drv_prim_fifo_lutram_reg: AF_THRESHOLD must be below N_ENTRIES");
    end
    if (AE_THRESHOLD >= N_ENTRIES) begin : g_chk_ae
        $error("qa_drv_prim_fifo_lutram_reg: AE_THRESHOLD must be below N_ENTRIES");
    end

    // Indices wrap at N_ENTRIES-2, so non-power-of-2 depths need an explicit compare.
    function automatic logic [AW-1:0] idx_advance(input logic [AW-1:0] idx);
        if (idx == IDX_LAST) begin
            return {AW{1'b0}};
        end else begin
            return idx + AW'(1'b1);
        end
    endfunction

    logic [N_DATA_BITS-1:0] head_r;
    logic [AW-1:0]          rd_idx_r;
    logic [AW-1:0]          wr_idx_r;
    logic [CW-1:0]          count_r;
    logic                   not_full_r;
    logic                   not_empty_r;
    logic                   almost_full_r;
    logic                   almost_empty_r;
    logic                   overflow_r;
    logic                   underflow_r;

    logic                   enq_ok_s;
    logic                   deq_ok_s;
    logic                   head_free_s;
    logic                   ram_has_data_s;
    logic                   load_ram_s;
    logic                   bypass_s;
    logic                   ram_we_s;
    logic [CW-1:0]          count_next_s;
    logic [N_DATA_BITS-1:0] ram_rd_data_s;

    qa_drv_prim_lutram_sdp #(
        .WIDTH (N_DATA_BITS),
        .DEPTH (RAM_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we_s),
        .wr_addr (wr_idx_r),
        .wr_data (enq_data),
        .rd_addr (rd_idx_r),
        .rd_data (ram_rd_data_s)
    );

    // Admission, head-refill selection and next occupancy; the RAM holds count-1 entries when the head is valid.
    always_comb begin
        enq_ok_s       = enq_en & not_full_r;
        deq_ok_s       = deq_en & not_empty_r;
        head_free_s    = ~not_empty_r | deq_ok_s;
        ram_has_data_s = (count_r > CW'(1'b1));
        load_ram_s     = head_free_s & ram_has_data_s;
        bypass_s       = head_free_s & ~ram_has_data_s & enq_ok_s;
        ram_we_s       = enq_ok_s & ~bypass_s;
        count_next_s   = count_r + CW'(enq_ok_s) - CW'(deq_ok_s);
    end

    // Head register, indices, occupancy, registered flags and sticky error flags.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            head_r         <= {N_DATA_BITS{1'b0}};
            rd_idx_r       <= {AW{1'b0}};
            wr_idx_r       <= {AW{1'b0}};
            count_r        <= {CW{1'b0}};
            not_full_r     <= 1'b1;
            not_empty_r    <= 1'b0;
            almost_full_r  <= AF_RESET;
            almost_empty_r <= 1'b1;
            overflow_r     <= 1'b0;
            underflow_r    <= 1'b0;
        end else begin
            if (load_ram_s) begin
                head_r   <= ram_rd_data_s;
                rd_idx_r <= idx_advance(rd_idx_r);
            end else if (bypass_s) begin
                head_r   <= enq_data;
            end
            if (ram_we_s) begin
                wr_idx_r <= idx_advance(wr_idx_r);
            end
            count_r        <= count_next_s;
            not_full_r     <= (count_next_s != FULL_COUNT);
            not_empty_r    <= (count_next_s != {CW{1'b0}});
            almost_full_r  <= (count_next_s >= AF_LEVEL);
            almost_empty_r <= (count_next_s <= AE_LEVEL);
            overflow_r     <= overflow_r  | (enq_en & ~not_full_r);
            underflow_r    <= underflow_r | (deq_en & ~not_empty_r);
        end
    end

    assign first       = head_r;
    assign count       = count_r;
    assign notFull     = not_full_r;
    assign notEmpty    = not_empty_r;
    assign almostFull  = almost_full_r;
    assign almostEmpty = almost_empty_r;
    assign overflow    = overflow_r;
    assign underflow   = underflow_r;

endmodule

// File: tb/tb_qa_drv_prim_fifo_lutram_reg.sv
// Randomised and directed checks of the head-register LUTRAM FIFO against a queue-based reference model.
module tb_qa_drv_prim_fifo_lutram_reg;

    localparam int DW = 16;
    localparam int NE = 5;
    localparam int AF = 1;
    localparam int AE = 1;

    logic          clk = 1'b0;
    logic          resetb = 1'b0;
    logic [DW-1:0] enq_data = '0;
    logic          enq_en = 1'b0;
    logic          deq_en = 1'b0;
    logic          notFull;
    logic          almostFull;
    logic [DW-1:0] first;
    logic          notEmpty;
    logic          almostEmpty;
    logic [2:0]    count;
    logic          overflow;
    logic          underflow;

    int n_checks = 0;
    int n_fails  = 0;

    logic [DW-1:0] model_q[$];
    logic          model_ovf = 1'b0;
    logic          model_unf = 1'b0;

    qa_drv_prim_fifo_lutram_reg #(
        .N_DATA_BITS  (DW),
        .N_ENTRIES    (NE),
        .AF_THRESHOLD (AF),
        .AE_THRESHOLD (AE)
    ) dut (
        .clk         (clk),
        .resetb      (resetb),
        .enq_data    (enq_data),
        .enq_en      (enq_en),
        .notFull     (notFull),
        .almostFull  (almostFull),
        .first       (first),
        .deq_en      (deq_en),
        .notEmpty    (notEmpty),
        .almostEmpty (almostEmpty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int sz;
        sz = model_q.size();
        check_eq("count",       32'(count),       32'(sz));
        check_eq("notFull",     32'(notFull),     32'(sz != NE));
        check_eq("notEmpty",    32'(notEmpty),    32'(sz != 0));
        check_eq("almostFull",  32'(almostFull),  32'(sz >= NE - AF));
        check_eq("almostEmpty", 32'(almostEmpty), 32'(sz <= AE));
        check_eq("overflow",    32'(overflow),    32'(model_ovf));
        check_eq("underflow",   32'(underflow),   32'(model_unf));
        if (sz > 0) begin
            check_eq("first", 32'(first), 32'(model_q[0]));
        end
    endtask

    task automatic check_reset_values();
        check_eq("rst_count",       32'(count),       32'd0);
        check_eq("rst_notFull",     32'(notFull),     32'd1);
        check_eq("rst_notEmpty",    32'(notEmpty),    32'd0);
        check_eq("rst_almostFull",  32'(almostFull),  32'd0);
        check_eq("rst_almostEmpty", 32'(almostEmpty), 32'd1);
        check_eq("rst_first",       32'(first),       32'd0);
        check_eq("rst_overflow",    32'(overflow),    32'd0);
        check_eq("rst_underflow",   32'(underflow),   32'd0);
    endtask

    task automatic model_reset();
        model_q.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
    endtask

    // One clock: drive inputs, apply the FIFO rules to the model at the edge, then compare.
    task automatic cycle(input logic e, input logic [DW-1:0] d, input logic q);
        int  sz;
        enq_en   = e;
        enq_data = d;
        deq_en   = q;
        @(posedge clk);
        sz = model_q.size();
        if (e && sz == NE) model_ovf = 1'b1;
        if (q && sz == 0)  model_unf = 1'b1;
        if (q && sz > 0)   void'(model_q.pop_front());
        if (e && sz < NE)  model_q.push_back(d);
        #1;
        enq_en = 1'b0;
        deq_en = 1'b0;
        check_outputs();
    endtask

    task automatic drain();
        for (int i = 0; i < NE + 1 && model_q.size() > 0; i++) begin
            cycle(1'b0, '0, 1'b1);
        end
    endtask

    initial begin
        #12;
        check_reset_values();
        #5;
        resetb = 1'b1;

        cycle(1'b1, 16'h0001, 1'b0);
        check_eq("enq1_first", 32'(first), 32'h0001);
        check_eq("enq1_ae",    32'(almostEmpty), 32'd1);
        drain();

        for (int i = 0; i < NE; i++) begin
            cycle(1'b1, DW'(16'h0010 + i), 1'b0);
            if (i == 3) begin
                check_eq("fill4_af",    32'(almostFull), 32'd1);
                check_eq("fill4_count", 32'(count),      32'd4);
            end
        end
        check_eq("fill5_notFull", 32'(notFull), 32'd0);
        for (int i = 0; i < NE; i++) begin
            check_eq("drain_order", 32'(first), 32'h10 + 32'(i));
            cycle(1'b0, '0, 1'b1);
        end
        check_eq("drained_notEmpty", 32'(notEmpty), 32'd0);

        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(16'h0100 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, DW'($urandom_range(0, 16'hFFFF)), 1'b1);
            check_eq("wrap_count", 32'(count), 32'd3);
        end
        drain();

        cycle(1'b1, 16'h00AA, 1'b0);
        cycle(1'b1, 16'h00BB, 1'b1);
        check_eq("bypass_first", 32'(first), 32'h00BB);
        check_eq("bypass_count", 32'(count), 32'd1);
        drain();

        for (int i = 0; i < NE; i++) cycle(1'b1, DW'(16'h0200 + i), 1'b0);
        cycle(1'b1, 16'h00EE, 1'b1);
        check_eq("full_ovf",   32'(overflow), 32'd1);
        check_eq("full_count", 32'(count),    32'd4);
        for (int i = 0; i < NE; i++) begin
            if (notEmpty) check_eq("no_ee", 32'(first == 16'h00EE), 32'd0);
            cycle(1'b0, '0, 1'b1);
        end
        cycle(1'b0, '0, 1'b1);
        check_eq("empty_unf",   32'(underflow), 32'd1);
        check_eq("empty_count", 32'(count),     32'd0);

        for (int i = 0; i < 400; i++) begin
            int bias;
            bias = (i < 200) ? 65 : 35;
            cycle(1'b1 == ($urandom_range(0, 99) < bias), DW'($urandom),
                  1'b1 == ($urandom_range(0, 99) >= bias - 20));
        end

        drain();
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(16'h0300 + i), 1'b0);
        #3;
        resetb = 1'b0;
        model_reset();
        #1;
        check_reset_values();
        #2;
        resetb = 1'b1;
        cycle(1'b1, 16'h0055, 1'b0);
        check_eq("post_rst_first", 32'(first), 32'h0055);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/qa_drv_prim_fifo_lutram_reg.md
# qa_drv_prim_fifo_lutram_reg

Parametrised LUTRAM FIFO for the QA driver primitives. It presents its head entry from a flop, so `first` carries no LUTRAM read path. It supports any depth of 2 or more, including non-power-of-2 depths. It provides an occupancy count, almost-full and almost-empty flags, and sticky overflow/underflow error flags in place of simulation-only fatal checks. It is the drop-in choice wherever a driver-side FIFO feeds timing-critical logic.

## Interface
- `N_DATA_BITS`, 32, entry width.
- `N_ENTRIES`, 4, total capacity including the output register; must be ≥ 2.
- `AF_THRESHOLD`, 1, `almostFull` asserts when free slots ≤ this value; must be < `N_ENTRIES`.
- `AE_THRESHOLD`, 1, `almostEmpty` asserts when occupancy ≤ this value; must be < `N_ENTRIES`.
- `clk`  in  1  sole clock.
- `resetb`  in  1  reset, asynchronous, active-low.
- `enq_data`  in  `N_DATA_BITS`  data to enqueue.
- `enq_en`  in  1  enqueue request.
- `notFull`  out  1  the FIFO can accept `enq_en` this cycle.
- `almostFull`  out  1  free slots ≤ `AF_THRESHOLD`.
- `first`  out  `N_DATA_BITS`  head entry, driven directly from a flop.
- `deq_en`  in  1  dequeue request.
- `notEmpty`  out  1  `first` is valid.
- `almostEmpty`  out  1  occupancy ≤ `AE_THRESHOLD`.
- `count`  out  `$clog2(N_ENTRIES+1)`  current occupancy.
- `overflow`  out  1  sticky: an enqueue was dropped.
- `underflow`  out  1  sticky: a dequeue was ignored.

## Operation
- Storage is the output register (head) plus a LUTRAM of `N_ENTRIES-1` slots.
  - LUTRAM write is synchronous; LUTRAM read is asynchronous.
  - Read and write indices have width max(1, `$clog2(N_ENTRIES-1)`).
- Index wrap: each index advances by 1 and returns to 0 after `N_ENTRIES-2`. This is not a power-of-2 mask.
- An enqueue is accepted only when `enq_en` and `notFull` (the registered value) are both 1.
  - `enq_en` while `notFull`=0 drops the data and sets `overflow`, even if `deq_en` is asserted in the same cycle.
- A dequeue is accepted only when `deq_en` and `notEmpty` are both 1.
  - `deq_en` while `notEmpty`=0 is ignored and sets `underflow`.
- Head refill priority, applied on each edge:
  1. The head is empty, or is being dequeued, and the LUTRAM is non-empty: the head loads `data[rd_idx]` and `rd_idx` advances.
  2. Else the head is empty, or is being dequeued, the LUTRAM is empty, and an enqueue is accepted: the head loads `enq_data` directly (bypass).
  3. Any other accepted enqueue writes the LUTRAM at `wr_idx`, and `wr_idx` advances.
- Count arithmetic: `count_next` = `count` + accepted enqueue − accepted dequeue. It never wraps, because the acceptance gating prevents it.
- Flags are computed from `count_next` and registered:
  - `notFull` = (`count_next` != `N_ENTRIES`).
  - `notEmpty` = (`count_next` != 0).
  - `almostFull` = (`count_next` ≥ `N_ENTRIES` − `AF_THRESHOLD`).
  - `almostEmpty` = (`count_next` ≤ `AE_THRESHOLD`).
- `overflow` and `underflow` clear only on reset.
- Elaboration `$error` is raised if any parameter rule above is violated.

## Timing
- Reset values of outputs and state:
  - `count`=0, `notFull`=1, `notEmpty`=0, `almostEmpty`=1.
  - `almostFull`=(`AF_THRESHOLD` ≥ `N_ENTRIES`), which is 0 for all legal parameter values.
  - `first`=0, `overflow`=0, `underflow`=0, both indices 0.
  - LUTRAM contents are not reset.
- Reset is asynchronous: asserting `resetb` mid-operation discards all contents immediately. Outputs take their reset values without waiting for a clock edge.
- Enqueue to `notEmpty`/`first` valid: 1 cycle, on the edge that accepts the enqueue, whatever the occupancy.
- Dequeue: the next head appears in `first` on the same edge, giving back-to-back dequeues at 1 per cycle.
- Simultaneous accepted enqueue and dequeue: `count` is unchanged and ordering is preserved. With one entry held, the bypass path makes `first` equal `enq_data` after the edge.
- Full with `deq_en` and `enq_en` together: the dequeue is accepted and the enqueue is dropped (`overflow`=1). The registered `notFull` is the only admission check.

## Structure
- Shared package `qa_drv_prim_fifo_pkg`: width helper functions for the index and counter widths, which may be reused by other FIFO variants.
- Sub-module `qa_drv_prim_lutram_sdp`: parameters for width and depth, synchronous write, asynchronous read, no reset, MLAB/distributed ram_style attributes.
- The top level holds the head register, indices, counter, flags and sticky error flags.

## Test plan
Bench parameters: `N_DATA_BITS`=16, `N_ENTRIES`=5, `AF_THRESHOLD`=1, `AE_THRESHOLD`=1.
- Reset, then enqueue 0x0001 → after 1 edge `first`=0x0001, `notEmpty`=1, `count`=1, `almostEmpty`=1.
- Enqueue 0x10–0x14 back-to-back:
  - after the 4th edge `almostFull`=1, `count`=4;
  - after the 5th edge `notFull`=0;
  - draining at 1 per cycle yields 0x10..0x14 in order, then `notEmpty`=0, `almostEmpty`=1.
- Wrap-around: 20 cycles of simultaneous enqueue/dequeue with occupancy held at 3 → every output in order and `count` stays 3. Covers the `rd_idx`/`wr_idx` wrap at 3 on the 4-slot LUTRAM.
- With one entry 0xAA held, simultaneous enqueue 0xBB and dequeue → `first`=0xBB after the edge, `count`=1 (bypass path).
- While full, `enq_en`+`deq_en` with 0xEE → `overflow`=1, `count`=4, and 0xEE never appears. `deq_en` while empty → `underflow`=1 and no state change.
- Assert `resetb` low between clock edges while holding 3 entries → outputs take reset values before the next edge. After release, enqueue 0x55 → `first`=0x55.
